// File: rtl/arc4_sched_pkg.sv
// Shared types and helpers for the ARC4 key-space scheduler.
// Holds the FSM state encoding, default widths and the cyclic priority search.
package arc4_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int KEY_W_DEF      = 24;
  localparam int CHUNK_LOG2_DEF = 12;
  localparam int MAX_N          = 64;

  // Index of the first set bit at or after start, wrapping at n.
  // Returns 0 when no bit within [0, n) is set.
  function automatic int first_one_from(
    input logic [MAX_N-1:0] vec,
    input int               n,
    input int               start
  );
    int   r;
    int   j;
    logic hit;
    r   = 0;
    hit = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      j = start + k;
      if (j >= n) j = j - n;
      if (k < n && !hit && vec[j[5:0]]) begin
        r   = j;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
// With ptr tied to zero it degenerates into a lowest-index priority encoder.
module rr_arbiter
  import arc4_sched_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [MAX_N-1:0] vec;
  int               r;

  // Pick the first eligible bit at or after ptr and form its one-hot.
  always_comb begin
    vec         = '0;
    vec[N-1:0]  = eligible;
    r           = first_one_from(vec, N, int'(ptr));
    idx         = IW'(r);
    gnt         = '0;
    if (|eligible) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/key_dispatch_sched.sv
// Dynamic chunk dispatcher for the multi-core ARC4 cracker.
// Hands out key chunks round-robin to idle cores and latches the first match.
module key_dispatch_sched
  import arc4_sched_pkg::*;
#(
  parameter int N_CORES    = 8,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int CHUNK_LOG2 = CHUNK_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic                     rdy,
  input  logic [N_CORES-1:0]       req,
  output logic [N_CORES-1:0]       gnt,
  output logic [KEY_W-1:0]         gnt_base,
  input  logic [N_CORES-1:0]       found,
  input  logic [N_CORES*KEY_W-1:0] found_key,
  output logic                     abort,
  output logic [KEY_W-1:0]         key,
  output logic                     key_valid,
  output logic                     exhausted
);

  localparam int CW   = KEY_W - CHUNK_LOG2 + 1;
  localparam int IW   = $clog2(N_CORES);
  localparam int NCH  = 1 << (KEY_W - CHUNK_LOG2);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  sched_state_t       state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [N_CORES-1:0] gnt_q, gnt_d;
  logic [KEY_W-1:0]   base_q, base_d;
  logic               abort_q, abort_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               kv_q, kv_d;
  logic               ex_q, ex_d;

  logic [N_CORES-1:0] elig;
  logic [N_CORES-1:0] g_oh;
  logic [IW-1:0]      g_idx;
  logic [N_CORES-1:0] f_oh;
  logic [IW-1:0]      f_idx;
  logic               g_any;
  logic               f_any;
  logic               hunting;

  assign elig = req & ~gnt_q;

  rr_arbiter #(.N(N_CORES)) u_gnt_arb (
    .eligible (elig),
    .ptr      (ptr_q),
    .gnt      (g_oh),
    .idx      (g_idx)
  );

  rr_arbiter #(.N(N_CORES)) u_found_arb (
    .eligible (found),
    .ptr      ('0),
    .gnt      (f_oh),
    .idx      (f_idx)
  );

  assign g_any   = |g_oh;
  assign f_any   = |f_oh;
  assign hunting = (state_q == RUN) || (state_q == DRAIN);

  // Next-state and next-output decode; a match outranks any grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    base_d  = base_q;
    abort_d = 1'b0;
    key_d   = key_q;
    kv_d    = kv_q;
    ex_d    = ex_q;
    if (hunting && f_any) begin
      key_d   = found_key[int'(f_idx)*KEY_W +: KEY_W];
      kv_d    = 1'b1;
      abort_d = 1'b1;
      state_d = DONE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (en) begin
            state_d = RUN;
            cnt_d   = '0;
            kv_d    = 1'b0;
            ex_d    = 1'b0;
          end
        end
        RUN: begin
          if (g_any && !cnt_q[CW-1]) begin
            gnt_d  = g_oh;
            base_d = {cnt_q[CW-2:0], {CHUNK_LOG2{1'b0}}};
            cnt_d  = cnt_q + 1'b1;
            ptr_d  = (g_idx == IW'(N_CORES - 1)) ? '0 : g_idx + 1'b1;
            if (cnt_q == LAST) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (&req) begin
            state_d = DONE;
            ex_d    = 1'b1;
            kv_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      base_q  <= '0;
      abort_q <= 1'b0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      ex_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      base_q  <= base_d;
      abort_q <= abort_d;
      key_q   <= key_d;
      kv_q    <= kv_d;
      ex_q    <= ex_d;
    end
  end

  assign rdy       = (state_q == IDLE) || (state_q == DONE);
  assign gnt       = gnt_q;
  assign gnt_base  = base_q;
  assign abort     = abort_q;
  assign key       = key_q;
  assign key_valid = kv_q;
  assign exhausted = ex_q;

endmodule

// File: tb/tb_key_dispatch_sched.sv
// Directed bench for key_dispatch_sched with 4 cores, 8-bit keys, 16 chunks.
// Every expected value below is worked out by hand from the intended behaviour.
module tb_key_dispatch_sched;

  localparam int N  = 4;
  localparam int KW = 8;
  localparam int CL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          rdy;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [KW-1:0] gnt_base;
  logic [N-1:0]  found;
  logic [N*KW-1:0] found_key;
  logic          abort;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          exhausted;

  int passed = 0;
  int total  = 0;

  key_dispatch_sched #(
    .N_CORES    (N),
    .KEY_W      (KW),
    .CHUNK_LOG2 (CL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .req       (req),
    .gnt       (gnt),
    .gnt_base  (gnt_base),
    .found     (found),
    .found_key (found_key),
    .abort     (abort),
    .key       (key),
    .key_valid (key_valid),
    .exhausted (exhausted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    req       = '0;
    found     = '0;
    found_key = '0;
    step();
    step();
    chk("rst_rdy", rdy, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_base", gnt_base, 0);
    chk("rst_abort", abort, 0);
    chk("rst_key", key, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_ex", exhausted, 0);
    rst_n = 1'b1;

    // full sweep with every core always requesting
    en = 1'b1;
    step();
    chk("run_rdy", rdy, 0);
    en  = 1'b0;
    req = 4'b1111;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("sweep_gnt", gnt, 32'(1 << (i % 4)));
      chk("sweep_base", gnt_base, 32'(i * 16));
      step();
    end
    chk("exh_gnt", gnt, 0);
    chk("exh_ex", exhausted, 1);
    chk("exh_kv", key_valid, 0);
    chk("exh_rdy", rdy, 1);

    // restart from DONE, then two simultaneous matches
    req = '0;
    en  = 1'b1;
    step();
    chk("re_rdy", rdy, 0);
    chk("re_ex", exhausted, 0);
    chk("re_kv", key_valid, 0);
    en  = 1'b0;
    req = 4'b0001;
    step();
    chk("re_gnt", gnt, 4'b0001);
    chk("re_base", gnt_base, 8'h00);
    req             = '0;
    en              = 1'b1;
    found           = 4'b0110;
    found_key[15:8] = 8'h37;
    found_key[23:16] = 8'h52;
    step();
    en    = 1'b0;
    found = '0;
    chk("m_key", key, 8'h37);
    chk("m_kv", key_valid, 1);
    chk("m_abort", abort, 1);
    chk("m_gnt", gnt, 0);
    chk("m_rdy", rdy, 1);
    step();
    chk("m_abort1", abort, 0);
    chk("m_hold_key", key, 8'h37);
    chk("m_hold_kv", key_valid, 1);
    found          = 4'b0001;
    found_key[7:0] = 8'hAA;
    step();
    found = '0;
    chk("done_ign_key", key, 8'h37);
    chk("done_ign_abort", abort, 0);

    // match collides with a grant to core 3
    en = 1'b1;
    step();
    chk("c_kv", key_valid, 0);
    en  = 1'b0;
    req = 4'b0010;
    step();
    chk("c_gnt1", gnt, 4'b0010);
    chk("c_base1", gnt_base, 8'h00);
    req            = 4'b1000;
    found          = 4'b0001;
    found_key[7:0] = 8'h9C;
    step();
    found = '0;
    req   = '0;
    chk("c_gnt", gnt, 0);
    chk("c_abort", abort, 1);
    chk("c_key", key, 8'h9C);
    chk("c_rdy", rdy, 1);

    // reset in the middle of a search
    en = 1'b1;
    step();
    en  = 1'b0;
    req = 4'b0100;
    step();
    chk("r_gnt", gnt, 4'b0100);
    req   = '0;
    rst_n = 1'b0;
    step();
    chk("r_rdy", rdy, 1);
    chk("r_gnt0", gnt, 0);
    chk("r_base0", gnt_base, 0);
    chk("r_abort", abort, 0);
    chk("r_key", key, 0);
    chk("r_kv", key_valid, 0);
    chk("r_ex", exhausted, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    en  = 1'b0;
    req = 4'b1111;
    step();
    chk("r2_gnt", gnt, 4'b0001);
    chk("r2_base", gnt_base, 8'h00);
    req = 4'b0010;
    step();
    chk("r3_gnt", gnt, 4'b0010);
    chk("r3_base", gnt_base, 8'h10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
